// File: rtl/shift_div_arbiter.sv
// Round-robin arbiter sharing one shift divider (I / 2^S, I % 2^S) among NREQ requesters.
// Optional macro SHDIV_ARB_PRIO0_EN: requester 0 always wins, others round-robin.

module shift_divider #(
   parameter int DW = 4
) (
   input  logic [2**DW-1:0] i_i,
   input  logic [DW-1:0]    s_i,
   output logic [2**DW-1:0] q_o,
   output logic [2**DW-1:0] r_o
);
   assign q_o = i_i >> s_i;
   assign r_o = i_i & ~({(2**DW){1'b1}} << s_i);
endmodule

module shift_div_arbiter #(
   parameter  int DW   = 4,
   parameter  int NREQ = 4,
   localparam int GW   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*2**DW-1:0] req_i,
   input  logic [NREQ*DW-1:0]   req_s,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [2**DW-1:0]     rsp_q,
   output logic [2**DW-1:0]     rsp_r,
   output logic [GW-1:0]        grant_id,
   output logic                 busy
);
   localparam int W = 2**DW;

   // Request handshake: req_valid[k] & req_ready[k] in IDLE; response handshake:
   // rsp_valid[grant_id] & rsp_ready[grant_id] in RESP.
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] grant_q;
   logic [W-1:0]  opi_q;
   logic [DW-1:0] ops_q;
   logic [W-1:0]  quo_q, rem_q;
   logic [W-1:0]  div_q, div_r;
   logic [GW-1:0] win, idx;
   logic          any_v, cand, req_fire;

   shift_divider #(.DW(DW)) u_div (
      .i_i (opi_q),
      .s_i (ops_q),
      .q_o (div_q),
      .r_o (div_r)
   );

   // Winner search starts at the pointer and wraps; NREQ is a power of two so GW-bit add wraps.
   always_comb begin
      win   = '0;
      idx   = '0;
      any_v = 1'b0;
      cand  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx  = ptr_q + k[GW-1:0];
         cand = req_valid[idx];
`ifdef SHDIV_ARB_PRIO0_EN
         cand = cand && (idx != '0);
`endif
         if (!any_v && cand) begin
            win   = idx;
            any_v = 1'b1;
         end
      end
`ifdef SHDIV_ARB_PRIO0_EN
      if (req_valid[0]) begin
         win   = '0;
         any_v = 1'b1;
      end
`endif
   end

   always_comb begin
      ptr_d = win + 1'b1;
`ifdef SHDIV_ARB_PRIO0_EN
      if (ptr_d == '0) ptr_d = {{(GW-1){1'b0}}, 1'b1};
      if (win == '0) ptr_d = ptr_q;
`endif
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      req_fire  = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by rst_n so no accept is advertised while reset is held.
            if (any_v && rst_n) begin
               req_ready[win] = 1'b1;
               req_fire       = 1'b1;
               state_d        = CALC;
            end
         end
         CALC: state_d = RESP;
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         opi_q   <= '0;
         ops_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         if (req_fire) begin
            opi_q   <= req_i[win*W +: W];
            ops_q   <= req_s[win*DW +: DW];
            grant_q <= win;
            ptr_q   <= ptr_d;
         end
         if (state_q == CALC) begin
            quo_q <= div_q;
            rem_q <= div_r;
         end
      end
   end

   assign rsp_q    = quo_q;
   assign rsp_r    = rem_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_div_arbiter.sv
// Directed bench for shift_div_arbiter (DW=4, NREQ=4); honours SHDIV_ARB_PRIO0_EN when defined.

module tb_shift_div_arbiter;
   localparam int DW   = 4;
   localparam int NREQ = 4;
   localparam int W    = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_i = '0;
   logic [NREQ*DW-1:0] req_s = '0;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready = '0;
   logic [W-1:0]      rsp_q, rsp_r;
   logic [1:0]        grant_id;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   // Per-requester operands for the continuous-request phase, with hand-computed results.
   logic [W-1:0]  tbl_i [NREQ] = '{16'h8001, 16'h00FF, 16'hABCD, 16'h1234};
   logic [DW-1:0] tbl_s [NREQ] = '{4'd1, 4'd4, 4'd8, 4'd12};
   logic [W-1:0]  tbl_q [NREQ] = '{16'h4000, 16'h000F, 16'h00AB, 16'h0001};
   logic [W-1:0]  tbl_r [NREQ] = '{16'h0001, 16'h000F, 16'h00CD, 16'h0234};

   shift_div_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_i     (req_i),
      .req_s     (req_s),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_q     (rsp_q),
      .rsp_r     (rsp_r),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation while several requesters may be holding req_valid; rsp_ready is high.
   task automatic rr_step(input int g);
      int n;
      logic [31:0] e;
      n = 0;
      while (req_ready == '0 && n < 20) begin tick(); n++; end
      check("rr_ready", 32'(req_ready), 32'(1 << g));
      exp_q.push_back({tbl_q[g], tbl_r[g]});
      tick();
      check("rr_busy", 32'(busy), 32'd1);
      check("rr_ready_calc", 32'(req_ready), 32'd0);
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << g));
      check("rr_grant", 32'(grant_id), 32'(g));
      e = exp_q.pop_front();
      check("rr_result", {rsp_q, rsp_r}, e);
      tick();
   endtask

   // One operation from a lone requester; operands are corrupted after the handshake.
   task automatic run_op(input int k, input logic [W-1:0] ii, input logic [DW-1:0] ss,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
      int n;
      req_i[k*W +: W]    = ii;
      req_s[k*DW +: DW]  = ss;
      req_valid[k]       = 1'b1;
      #1;
      n = 0;
      while (!req_ready[k] && n < 20) begin tick(); n++; end
      check("op_req_ready", 32'(req_ready), 32'(1 << k));
      tick();
      req_valid[k]      = 1'b0;
      req_i[k*W +: W]   = ~ii;
      req_s[k*DW +: DW] = ~ss;
      n = 0;
      while (!rsp_valid[k] && n < 20) begin tick(); n++; end
      check("op_latency", 32'(n), 32'd1);
      check("op_rsp_valid", 32'(rsp_valid), 32'(1 << k));
      check("op_rsp_q", 32'(rsp_q), 32'(eq));
      check("op_rsp_r", 32'(rsp_r), 32'(er));
      check("op_grant", 32'(grant_id), 32'(k));
      rsp_ready[k] = 1'b1;
      tick();
      rsp_ready[k] = 1'b0;
      check("op_done_valid", 32'(rsp_valid), 32'd0);
      check("op_done_busy", 32'(busy), 32'd0);
      check("op_hold_q", 32'(rsp_q), 32'(eq));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int k = 0; k < NREQ; k++) begin
         req_i[k*W +: W]   = tbl_i[k];
         req_s[k*DW +: DW] = tbl_s[k];
      end
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_q", 32'(rsp_q), 32'd0);
      check("rst_rsp_r", 32'(rsp_r), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;

`ifdef SHDIV_ARB_PRIO0_EN
      req_valid = 4'b0011;
      for (int j = 0; j < 3; j++) rr_step(0);
      req_valid = 4'b0010;
      rr_step(1);
`else
      for (int j = 0; j < 5; j++) rr_step(j % NREQ);
`endif
      req_valid = '0;
      rsp_ready = '0;
      tick();

      run_op(2, 16'hABCD, 4'd4, 16'h0ABC, 16'h000D);
      run_op(0, 16'h1234, 4'd0, 16'h1234, 16'h0000);
      run_op(3, 16'hFFFF, 4'd15, 16'h0001, 16'h7FFF);

      // Backpressure on requester 1 while requester 2 waits and requester 3 drives rsp_ready.
      req_i[1*W +: W]   = 16'hBEEF;
      req_s[1*DW +: DW] = 4'd4;
      req_valid[1]      = 1'b1;
      #1;
      n = 0;
      while (!req_ready[1] && n < 20) begin tick(); n++; end
      check("bp_req_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid[1]      = 1'b0;
      req_i[2*W +: W]   = 16'h00F0;
      req_s[2*DW +: DW] = 4'd4;
      req_valid[2]      = 1'b1;
      tick();
      rsp_ready = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
         check("bp_rsp_q", 32'(rsp_q), 32'h0BEE);
         check("bp_rsp_r", 32'(rsp_r), 32'h000F);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = 4'b0000;
      check("bp_waiter_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      tick();
      check("bp_waiter_valid", 32'(rsp_valid), 32'b0100);
      check("bp_waiter_q", 32'(rsp_q), 32'h000F);
      check("bp_waiter_r", 32'(rsp_r), 32'h0000);
      rsp_ready = 4'b0100;
      tick();
      rsp_ready = '0;

      // Reset during CALC: pointer would otherwise sit at 3.
      req_i[2*W +: W]   = 16'h5555;
      req_s[2*DW +: DW] = 4'd1;
      req_valid[2]      = 1'b1;
      #1;
      check("ab_req_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check("ab_busy_calc", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_rsp_valid", 32'(rsp_valid), 32'd0);
      check("ab_rsp_q", 32'(rsp_q), 32'd0);
      check("ab_rsp_r", 32'(rsp_r), 32'd0);
      check("ab_grant", 32'(grant_id), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("ab_no_stale_valid", 32'(rsp_valid), 32'd0);
         check("ab_idle", 32'(busy), 32'd0);
      end
      req_valid = 4'b1010;
      #1;
      check("ab_ptr_zero", 32'(req_ready), 32'b0010);
      req_valid = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
